// File: rtl/vip_downscale_2x_pkg.sv
// vip_downscale_2x_pkg: shared constants and sizing helpers for the 2x2 downscaler.
package vip_downscale_2x_pkg;
    localparam int RND = 2;
    function automatic int ram_aw(input int width);
        return (width / 2 > 1) ? $clog2(width / 2) : 1;
    endfunction
endpackage

// File: rtl/vip_downscale_2x_line_ram.sv
// vip_line_ram: simple dual-port line RAM, synchronous write, one-cycle registered read.
module vip_line_ram
    import vip_downscale_2x_pkg::*;
#(
    parameter int DEPTH = 640,
    parameter int DW    = 9,
    parameter int AW    = ram_aw(2 * DEPTH)
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic          re_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);
    logic [DW-1:0] mem_q [DEPTH];
    always_ff @(posedge clk_i) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
        if (re_i) rdata_o <= mem_q[raddr_i];
    end
endmodule

// File: rtl/vip_downscale_2x.sv
// vip_downscale_2x: halves width and height by the rounded mean of each 2x2 block; bypass keeps the same 2-cycle latency.
module vip_downscale_2x
    import vip_downscale_2x_pkg::*;
#(
    parameter int BITS   = 8,
    parameter int WIDTH  = 1280,
    parameter int HEIGHT = 960
) (
    input  logic            pclk,
    input  logic            rst,
    input  logic            enable,
    input  logic            in_href,
    input  logic            in_vsync,
    input  logic [BITS-1:0] in_data,
    output logic            out_href,
    output logic            out_vsync,
    output logic [BITS-1:0] out_data,
    output logic            line_overflow
);
    localparam int DEPTH = WIDTH / 2;
    localparam int AW    = ram_aw(WIDTH);

    if (WIDTH < 4 || HEIGHT < 2) begin : g_param_check
        $error("vip_downscale_2x: WIDTH must be >= 4 and HEIGHT >= 2");
    end

    logic [1:0]      vs_q, vs_d;
    logic            href_q, mode_q, mode_d, act_q, act_d;
    logic            lpar_q, lpar_d, cpar_q, cpar_d, ovf_q, ovf_d;
    logic [AW:0]     addr_q, addr_d;
    logic [BITS-1:0] p0_q, p0_d;
    logic            v1_q, v1_d, byp1_q, byp1_d;
    logic [BITS:0]   d1_q, d1_d;
    logic            out_href_q, out_href_d;
    logic [BITS-1:0] out_data_q, out_data_d;
    logic            fs, ls, lpar, cpar, pix, pair, ovf_now, ok, we, re;
    logic [AW:0]     addr;
    logic [BITS:0]   hsum, ram_q;
    logic [BITS+1:0] sum;

    always_comb begin
        fs      = vs_q[0] & ~in_vsync;
        ls      = ~href_q & in_href;
        mode_d  = fs ? enable : mode_q;
        act_d   = fs | act_q;
        lpar    = fs ? 1'b0 : lpar_q;
        lpar_d  = fs ? 1'b0 : lpar_q ^ (href_q & ~in_href);
        cpar    = ls ? 1'b0 : cpar_q;
        addr    = ls ? '0 : addr_q;
        cpar_d  = cpar ^ in_href;
        pix     = in_href & act_d;
        pair    = pix & mode_d & cpar;
        ovf_now = pair & (addr == (AW+1)'(DEPTH));
        ok      = pair & ~ovf_now;
        we      = ok & ~lpar;
        re      = ok & lpar;
        hsum    = {1'b0, p0_q} + {1'b0, in_data};
        addr_d  = addr + (AW+1)'(ok);
        p0_d    = (in_href & ~cpar) ? in_data : p0_q;
        ovf_d   = (fs ? 1'b0 : ovf_q) | ovf_now;
        vs_d    = {vs_q[0], in_vsync};
        // Bypass shares the stage-1 data register so both modes see the same latency
        v1_d    = mode_d ? re : pix;
        byp1_d  = ~mode_d;
        d1_d    = mode_d ? hsum : {1'b0, in_data};
        sum     = {1'b0, d1_q} + {1'b0, ram_q} + (BITS+2)'(RND);
        out_href_d = v1_q;
        out_data_d = ~v1_q ? '0 : byp1_q ? d1_q[BITS-1:0] : BITS'(sum >> 2);
    end

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            vs_q       <= '0;
            href_q     <= 1'b0;
            mode_q     <= 1'b0;
            act_q      <= 1'b0;
            lpar_q     <= 1'b0;
            cpar_q     <= 1'b0;
            ovf_q      <= 1'b0;
            addr_q     <= '0;
            p0_q       <= '0;
            v1_q       <= 1'b0;
            byp1_q     <= 1'b0;
            d1_q       <= '0;
            out_href_q <= 1'b0;
            out_data_q <= '0;
        end else begin
            vs_q       <= vs_d;
            href_q     <= in_href;
            mode_q     <= mode_d;
            act_q      <= act_d;
            lpar_q     <= lpar_d;
            cpar_q     <= cpar_d;
            ovf_q      <= ovf_d;
            addr_q     <= addr_d;
            p0_q       <= p0_d;
            v1_q       <= v1_d;
            byp1_q     <= byp1_d;
            d1_q       <= d1_d;
            out_href_q <= out_href_d;
            out_data_q <= out_data_d;
        end
    end

    vip_line_ram #(.DEPTH(DEPTH), .DW(BITS + 1), .AW(AW)) u_ram (
        .clk_i   (pclk),
        .we_i    (we),
        .waddr_i (addr[AW-1:0]),
        .wdata_i (hsum),
        .re_i    (re),
        .raddr_i (addr[AW-1:0]),
        .rdata_o (ram_q)
    );

    assign out_href      = out_href_q;
    assign out_data      = out_data_q;
    assign out_vsync     = vs_q[1];
    assign line_overflow = ovf_q;
endmodule

// File: tb/tb_vip_downscale_2x.sv
// tb_vip_downscale_2x: frame-level reference model with per-cycle comparison plus literal test-plan checks.
module tb_vip_downscale_2x;
    localparam int BITS = 8, WIDTH = 8, HEIGHT = 8, DEPTH = WIDTH / 2, N = 6000;

    logic clk = 0, rst = 1, enable = 0, in_href = 0, in_vsync = 0;
    logic [BITS-1:0] in_data = 0;
    logic out_href, out_vsync, line_overflow;
    logic [BITS-1:0] out_data;

    vip_downscale_2x #(.BITS(BITS), .WIDTH(WIDTH), .HEIGHT(HEIGHT)) dut (
        .pclk(clk), .rst(rst), .enable(enable), .in_href(in_href), .in_vsync(in_vsync),
        .in_data(in_data), .out_href(out_href), .out_vsync(out_vsync),
        .out_data(out_data), .line_overflow(line_overflow)
    );

    always #5 clk = ~clk;
    int pc = 0;
    always @(posedge clk) pc <= pc + 1;

    int checks = 0, errors = 0, mark = 0;
    bit eh [N];
    int ed [N];
    bit evs [N];
    bit eov [N];
    int mq[$], dq[$], outpc[$];
    logic [7:0] img [0:9][0:9];

    // model state: frame/line/pixel counters and the pixels of the last even-line pair per column pair
    bit m_pvs, m_ph, m_mode, m_act, m_ovf;
    int m_line, m_pcnt, m_hold;
    int ram_a [DEPTH], ram_b [DEPTH];

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", nm, got, exp);
        end
    endtask

    task automatic model(input bit r, h, v, input int d, input bit e, input int c);
        bit oh;
        int od, k;
        oh = 0;
        od = 0;
        if (c + 1 >= N) begin
            $display("FAIL model_bound got %0d expected below %0d", c + 1, N);
            $fatal(1);
        end
        if (r) begin
            {m_pvs, m_ph, m_mode, m_act, m_ovf} = '0;
            m_line = 0; m_pcnt = 0; m_hold = 0;
            eh[c] = 0; ed[c] = 0; eh[c+1] = 0; ed[c+1] = 0;
            evs[c] = 0; evs[c+1] = 0; eov[c] = 0;
            return;
        end
        if (m_pvs && !v) begin
            m_mode = e; m_act = 1; m_line = 0; m_ovf = 0;
        end else if (m_ph && !h) m_line++;
        if (!m_ph && h) m_pcnt = 0;
        if (h) begin
            if (m_act && !m_mode) begin
                oh = 1; od = d;
            end else if (m_act && m_pcnt % 2 == 1) begin
                k = m_pcnt / 2;
                if (k >= DEPTH) m_ovf = 1;
                else if (m_line % 2 == 0) begin
                    ram_a[k] = m_hold; ram_b[k] = d;
                end else begin
                    oh = 1; od = (ram_a[k] + ram_b[k] + m_hold + d + 2) / 4;
                end
            end
            if (m_pcnt % 2 == 0) m_hold = d;
            m_pcnt++;
        end
        if (oh) mq.push_back(od);
        m_ph = h; m_pvs = v;
        eh[c+1] = oh; ed[c+1] = od; evs[c+1] = v; eov[c] = m_ovf;
    endtask

    always @(negedge clk) begin
        int i;
        if (pc > 0) begin
            i = pc - 1;
            chk("out_href", out_href, eh[i]);
            chk("out_data", out_data, ed[i]);
            chk("out_vsync", out_vsync, evs[i]);
            chk("line_overflow", line_overflow, eov[i]);
            if (out_href === 1'b1) begin
                dq.push_back(out_data);
                outpc.push_back(i);
            end
        end
    end

    task automatic tick(input bit r, h, v, input logic [7:0] d, input bit e);
        @(negedge clk);
        #1;
        rst = r; in_href = h; in_vsync = v; in_data = d; enable = e;
        model(r, h, v, int'(d), e, pc);
        if (r) begin
            #1;
            chk("rst_out_href", out_href, 0);
            chk("rst_out_data", out_data, 0);
            chk("rst_line_overflow", line_overflow, 0);
        end
    endtask

    task automatic frame(input int w, input int hl, input bit e, input bit flip, input bit fsp);
        tick(0, 0, 1, 0, e);
        tick(0, 0, 1, 0, e);
        if (!fsp) tick(0, 0, 0, 0, e);
        for (int r = 0; r < hl; r++) begin
            for (int c = 0; c < w; c++) begin
                tick(0, 1, 0, img[r][c], (r == 0 && c == 0) ? e : e ^ flip);
                if (r == 1 && c == 1) mark = pc;
            end
            tick(0, 0, 0, 0, e ^ flip);
            tick(0, 0, 0, 0, e ^ flip);
        end
        repeat (3) tick(0, 0, 0, 0, e ^ flip);
    endtask

    task automatic clrq();
        mq.delete(); dq.delete(); outpc.delete();
    endtask

    task automatic expect_list(input string nm, input int exp[$]);
        chk({nm, "_count_dut"}, dq.size(), exp.size());
        chk({nm, "_count_model"}, mq.size(), exp.size());
        for (int i = 0; i < exp.size(); i++) begin
            if (i < dq.size()) chk($sformatf("%s_dut_%0d", nm, i), dq[i], exp[i]);
            if (i < mq.size()) chk($sformatf("%s_model_%0d", nm, i), mq[i], exp[i]);
        end
    endtask

    task automatic fill_rand();
        for (int r = 0; r < 10; r++)
            for (int c = 0; c < 10; c++) img[r][c] = 8'($urandom_range(255));
    endtask

    task automatic fill_4x4();
        int v[16];
        v = '{10, 20, 30, 40, 50, 60, 70, 80, 1, 2, 3, 4, 5, 6, 7, 8};
        for (int i = 0; i < 16; i++) img[i / 4][i % 4] = 8'(v[i]);
    endtask

    initial begin
        repeat (3) tick(1, 0, 0, 0, 0);
        repeat (4) tick(0, 1, 0, 8'd77, 1);
        repeat (3) tick(0, 0, 0, 0, 1);
        chk("pre_frame_pulses", dq.size(), 0);

        for (int r = 0; r < 10; r++) for (int c = 0; c < 10; c++) img[r][c] = 8'd255;
        clrq();
        frame(8, 2, 1, 0, 0);
        expect_list("sat255", '{255, 255, 255, 255});
        chk("sat255_ovf", line_overflow, 0);

        fill_4x4();
        clrq();
        frame(4, 4, 1, 0, 0);
        expect_list("blk4x4", '{35, 55, 4, 6});
        if (outpc.size() > 0) chk("blk4x4_latency", outpc[0], mark + 1);

        fill_rand();
        clrq();
        frame(5, 3, 1, 0, 0);
        chk("w5h3_count", dq.size(), 2);

        for (int i = 0; i < 6; i++) img[i / 3][i % 3] = 8'(i + 1);
        clrq();
        frame(3, 2, 0, 0, 0);
        expect_list("bypass", '{1, 2, 3, 4, 5, 6});

        fill_rand();
        clrq();
        frame(4, 2, 1, 1, 0);
        chk("toggle_keep_down", dq.size(), 2);
        clrq();
        frame(4, 2, 0, 1, 0);
        chk("toggle_keep_bypass", dq.size(), 8);

        clrq();
        frame(10, 2, 1, 0, 0);
        chk("ovf_count", dq.size(), 4);
        chk("ovf_set", line_overflow, 1);
        clrq();
        frame(2, 2, 1, 0, 0);
        chk("ovf_clear", line_overflow, 0);
        chk("ovf_next_count", dq.size(), 1);

        fill_4x4();
        clrq();
        frame(4, 2, 1, 0, 1);
        expect_list("fs_pixel", '{35, 55});

        tick(0, 0, 1, 0, 0);
        tick(0, 0, 0, 0, 0);
        tick(0, 1, 0, 8'd9, 0);
        tick(0, 1, 0, 8'd10, 0);
        tick(1, 1, 0, 8'd11, 0);
        tick(1, 0, 0, 0, 0);
        clrq();
        repeat (4) tick(0, 1, 0, 8'd12, 1);
        repeat (4) tick(0, 0, 0, 0, 1);
        chk("post_rst_pulses", dq.size(), 0);
        fill_4x4();
        clrq();
        frame(4, 4, 1, 0, 0);
        expect_list("post_rst_frame", '{35, 55, 4, 6});

        for (int f = 0; f < 8; f++) begin
            fill_rand();
            frame($urandom_range(10, 2), $urandom_range(5, 2), 1'($urandom_range(1)),
                  1'($urandom_range(1)), 1'($urandom_range(1)));
        end
        repeat (3) tick(0, 0, 0, 0, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
